dti_pattern_src: RTL

//  Synthesizable DTI producer: drives a data/valid/ready channel with a burst of
//  cfg_len words, either incrementing or LFSR, with cfg_gap idle cycles between words.

---
 rtl/dti_src_pkg.sv | 9 +
 rtl/dti_lfsr_step.sv | 14 +
 rtl/dti_pattern_src.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dti_src_pkg.sv
// Shared types for the DTI pattern source and its sink-side companions.
package dti_src_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} src_state_t;
    typedef enum logic {MODE_INCR, MODE_LFSR} src_mode_t;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

endpackage

// File: rtl/dti_lfsr_step.sv
// One LFSR step: shift left, feed back XOR of tapped bits into bit 0.
module dti_lfsr_step
    import dti_src_pkg::*;
#(
    parameter int                W_DATA = 16,
    parameter logic [W_DATA-1:0] TAPS   = W_DATA'(DEFAULT_TAPS)
) (
    input  logic [W_DATA-1:0] cur_i,
    output logic [W_DATA-1:0] nxt_o
);

    assign nxt_o = {cur_i[W_DATA-2:0], ^(cur_i & TAPS)};

endmodule

// File: rtl/dti_pattern_src.sv
// DTI burst producer: incrementing or LFSR words with optional idle gaps.
module dti_pattern_src
    import dti_src_pkg::*;
#(
    parameter int                W_DATA = 16,
    parameter int                W_CNT  = 16,
    parameter int                W_GAP  = 8,
    parameter logic [W_DATA-1:0] TAPS   = W_DATA'(DEFAULT_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_CNT-1:0]  cfg_len,
    input  logic [W_GAP-1:0]  cfg_gap,
    input  logic              cfg_mode,
    input  logic [W_DATA-1:0] cfg_seed,
    output logic [W_DATA-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [W_CNT-1:0]  sent_cnt
);

    src_state_t        state_q, state_d;
    src_mode_t         mode_q, mode_d;
    logic [W_DATA-1:0] data_q, data_d;
    logic [W_CNT-1:0]  sent_q, sent_d;
    logic [W_CNT-1:0]  len_q, len_d;
    logic [W_GAP-1:0]  gap_q, gap_d;
    logic [W_GAP-1:0]  gcnt_q, gcnt_d;
    logic [W_DATA-1:0] lfsr_nxt;

    dti_lfsr_step #(
        .W_DATA (W_DATA),
        .TAPS   (TAPS)
    ) u_step (
        .cur_i (data_q),
        .nxt_o (lfsr_nxt)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        sent_d  = sent_q;
        len_d   = len_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = cfg_len;
                    gap_d  = cfg_gap;
                    mode_d = src_mode_t'(cfg_mode);
                    sent_d = '0;
                    // An all-zero LFSR would lock up, so seed 0 becomes 1.
                    if (cfg_mode && cfg_seed == '0)
                        data_d = W_DATA'(1);
                    else
                        data_d = cfg_seed;
                    state_d = (cfg_len == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (dout_ready) begin
                    sent_d = sent_q + W_CNT'(1);
                    if (mode_q == MODE_LFSR)
                        data_d = lfsr_nxt;
                    else
                        data_d = data_q + W_DATA'(1);
                    if (sent_d == len_q) begin
                        state_d = DONE;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                        gcnt_d  = gap_q - W_GAP'(1);
                    end
                end
            end
            GAP: begin
                if (gcnt_q == '0)
                    state_d = SEND;
                else
                    gcnt_d = gcnt_q - W_GAP'(1);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_INCR;
            data_q  <= '0;
            sent_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign dout_valid = (state_q == SEND);
    assign dout_data  = data_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign sent_cnt   = sent_q;

endmodule
